// File: rtl/snake_pkg.sv
// Shared types for the snake engine: direction codes, FSM state encoding and
// the reversal helper used to reject 180-degree turns.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_COMMIT = 2'b10,
        ST_DEAD   = 2'b11
    } state_e;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_if.sv
// Control/status bundle between the snake engine and its surroundings
// (direction logic, apple generator, pixel renderer).
interface snake_if #(
    parameter int X_W   = 6,
    parameter int Y_W   = 6,
    parameter int LEN_W = 7
);
    logic             in_tick;
    logic             in_dir_valid;
    logic [1:0]       in_dir;
    logic [X_W-1:0]   in_apple_x;
    logic [Y_W-1:0]   in_apple_y;
    logic [X_W-1:0]   in_query_x;
    logic [Y_W-1:0]   in_query_y;
    logic             out_query_hit;
    logic [X_W-1:0]   out_head_x;
    logic [Y_W-1:0]   out_head_y;
    logic [LEN_W-1:0] out_length;
    logic             out_busy;
    logic             out_step_done;
    logic             out_ate;
    logic             out_dead;
    logic             out_tick_overrun;

    modport master (
        output in_tick, in_dir_valid, in_dir, in_apple_x, in_apple_y, in_query_x, in_query_y,
        input  out_query_hit, out_head_x, out_head_y, out_length, out_busy, out_step_done,
               out_ate, out_dead, out_tick_overrun
    );

    modport slave (
        input  in_tick, in_dir_valid, in_dir, in_apple_x, in_apple_y, in_query_x, in_query_y,
        output out_query_hit, out_head_x, out_head_y, out_length, out_busy, out_step_done,
               out_ate, out_dead, out_tick_overrun
    );
endinterface

// File: rtl/snake_occupancy_map.sv
// One bit per grid cell marking body occupancy. Reset loads the initial body;
// one set and one clear per cycle, combinational collision peek, registered render query.
module snake_occupancy_map #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int X_W      = 6,
    parameter int Y_W      = 6,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 32,
    parameter int INIT_Y   = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           set_en,
    input  logic [X_W-1:0] set_x,
    input  logic [Y_W-1:0] set_y,
    input  logic           clr_en,
    input  logic [X_W-1:0] clr_x,
    input  logic [Y_W-1:0] clr_y,
    input  logic [X_W-1:0] chk_x,
    input  logic [Y_W-1:0] chk_y,
    output logic           chk_hit,
    input  logic [X_W-1:0] query_x,
    input  logic [Y_W-1:0] query_y,
    output logic           query_hit
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);

    function automatic logic [CELLS-1:0] init_mask();
        logic [CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < INIT_LEN; i++) m[IDX_W'(INIT_Y * GRID_W + INIT_X - i)] = 1'b1;
        return m;
    endfunction

    localparam logic [CELLS-1:0] INIT_MASK = init_mask();

    function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
    endfunction

    function automatic logic in_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < GRID_W) && (int'(y) < GRID_H);
    endfunction

    logic [CELLS-1:0] bits_q, bits_d;
    logic             query_hit_q, query_hit_d;

    always_comb begin
        bits_d = bits_q;
        // Set after clear so a head moving into the vacating tail stays marked.
        if (clr_en) bits_d[cell_idx(clr_x, clr_y)] = 1'b0;
        if (set_en) bits_d[cell_idx(set_x, set_y)] = 1'b1;
        query_hit_d = in_grid(query_x, query_y) && bits_q[cell_idx(query_x, query_y)];
        chk_hit     = in_grid(chk_x, chk_y) && bits_q[cell_idx(chk_x, chk_y)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q      <= INIT_MASK;
            query_hit_q <= 1'b0;
        end else begin
            bits_q      <= bits_d;
            query_hit_q <= query_hit_d;
        end
    end

    assign query_hit = query_hit_q;

endmodule

// File: rtl/snake_engine.sv
// Grid snake core: ring buffer of body cells, direction handling and a
// IDLE/CALC/COMMIT/DEAD step machine; occupancy lives in snake_occupancy_map.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int X_W      = 6,
    parameter int Y_W      = 6,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 32,
    parameter int INIT_Y   = 24,
    parameter int WRAP     = 0
) (
    input logic  in_clock,
    input logic  in_reset,
    snake_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d, pend_q, pend_d, step_dir_q, step_dir_d;
    logic [X_W-1:0]     head_x_q, head_x_d, next_x_q, next_x_d;
    logic [Y_W-1:0]     head_y_q, head_y_d, next_y_q, next_y_d;
    logic               eat_q, eat_d, grow_q, grow_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
    logic [X_W-1:0]     ring_x_q [MAX_LEN];
    logic [X_W-1:0]     ring_x_d [MAX_LEN];
    logic [Y_W-1:0]     ring_y_q [MAX_LEN];
    logic [Y_W-1:0]     ring_y_d [MAX_LEN];
    logic               done_q, done_d, ate_q, ate_d, dead_q, dead_d, ovr_q, ovr_d;

    logic [X_W:0]       cx_ext;
    logic [Y_W:0]       cy_ext;
    logic [X_W-1:0]     cx, tail_x;
    logic [Y_W-1:0]     cy, tail_y;
    logic               wall_x, wall_y, c_eat, c_grow, chk_hit, self_hit, set_en, clr_en;

    // Candidate head: computed one bit wider so walls are seen before truncation.
    always_comb begin
        cx_ext = {1'b0, head_x_q};
        cy_ext = {1'b0, head_y_q};
        case (pend_q)
            DIR_UP:    cy_ext = cy_ext - (Y_W+1)'(1);
            DIR_DOWN:  cy_ext = cy_ext + (Y_W+1)'(1);
            DIR_LEFT:  cx_ext = cx_ext - (X_W+1)'(1);
            default:   cx_ext = cx_ext + (X_W+1)'(1);
        endcase
        wall_x = cx_ext >= (X_W+1)'(GRID_W);
        wall_y = cy_ext >= (Y_W+1)'(GRID_H);
        cx = cx_ext[X_W-1:0];
        cy = cy_ext[Y_W-1:0];
        if (WRAP != 0 && wall_x) cx = (pend_q == DIR_LEFT) ? X_W'(GRID_W - 1) : '0;
        if (WRAP != 0 && wall_y) cy = (pend_q == DIR_UP)   ? Y_W'(GRID_H - 1) : '0;
        tail_x   = ring_x_q[tail_ptr_q];
        tail_y   = ring_y_q[tail_ptr_q];
        c_eat    = (cx == bus.in_apple_x) && (cy == bus.in_apple_y);
        c_grow   = c_eat && (length_q < LEN_W'(MAX_LEN));
        self_hit = chk_hit && !((cx == tail_x) && (cy == tail_y) && !c_grow);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        step_dir_d = step_dir_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        next_x_d   = next_x_q;
        next_y_d   = next_y_q;
        eat_d      = eat_q;
        grow_d     = grow_q;
        length_d   = length_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        ring_x_d   = ring_x_q;
        ring_y_d   = ring_y_q;
        done_d     = 1'b0;
        ate_d      = 1'b0;
        dead_d     = dead_q;
        ovr_d      = 1'b0;
        set_en     = 1'b0;
        clr_en     = 1'b0;

        if (bus.in_dir_valid && dir_e'(bus.in_dir) != opposite_dir(dir_q))
            pend_d = dir_e'(bus.in_dir);

        case (state_q)
            ST_IDLE: if (bus.in_tick && !dead_q) state_d = ST_CALC;
            ST_CALC: begin
                ovr_d = bus.in_tick;
                if ((WRAP == 0 && (wall_x || wall_y)) || self_hit) begin
                    dead_d  = 1'b1;
                    state_d = ST_DEAD;
                end else begin
                    next_x_d   = cx;
                    next_y_d   = cy;
                    eat_d      = c_eat;
                    grow_d     = c_grow;
                    step_dir_d = pend_q;
                    state_d    = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                ovr_d      = bus.in_tick;
                set_en     = 1'b1;
                head_ptr_d = head_ptr_q + PTR_W'(1);
                ring_x_d[head_ptr_d] = next_x_q;
                ring_y_d[head_ptr_d] = next_y_q;
                if (grow_q) length_d = length_q + LEN_W'(1);
                else begin
                    clr_en     = 1'b1;
                    tail_ptr_d = tail_ptr_q + PTR_W'(1);
                end
                head_x_d = next_x_q;
                head_y_d = next_y_q;
                dir_d    = step_dir_q;
                done_d   = 1'b1;
                ate_d    = eat_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_DEAD;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            step_dir_q <= DIR_RIGHT;
            head_x_q   <= X_W'(INIT_X);
            head_y_q   <= Y_W'(INIT_Y);
            next_x_q   <= '0;
            next_y_q   <= '0;
            eat_q      <= 1'b0;
            grow_q     <= 1'b0;
            length_q   <= LEN_W'(INIT_LEN);
            head_ptr_q <= PTR_W'(INIT_LEN - 1);
            tail_ptr_q <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                ring_x_q[PTR_W'(i)] <= (i < INIT_LEN) ? X_W'(INIT_X - INIT_LEN + 1 + i) : '0;
                ring_y_q[PTR_W'(i)] <= Y_W'(INIT_Y);
            end
            done_q <= 1'b0;
            ate_q  <= 1'b0;
            dead_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            step_dir_q <= step_dir_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            next_x_q   <= next_x_d;
            next_y_q   <= next_y_d;
            eat_q      <= eat_d;
            grow_q     <= grow_d;
            length_q   <= length_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            ring_x_q   <= ring_x_d;
            ring_y_q   <= ring_y_d;
            done_q     <= done_d;
            ate_q      <= ate_d;
            dead_q     <= dead_d;
            ovr_q      <= ovr_d;
        end
    end

    snake_occupancy_map #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
        .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) u_map (
        .clk(in_clock), .rst(in_reset),
        .set_en(set_en), .set_x(next_x_q), .set_y(next_y_q),
        .clr_en(clr_en), .clr_x(tail_x), .clr_y(tail_y),
        .chk_x(cx), .chk_y(cy), .chk_hit(chk_hit),
        .query_x(bus.in_query_x), .query_y(bus.in_query_y), .query_hit(bus.out_query_hit)
    );

    assign bus.out_head_x       = head_x_q;
    assign bus.out_head_y       = head_y_q;
    assign bus.out_length       = length_q;
    assign bus.out_busy         = (state_q != ST_IDLE);
    assign bus.out_step_done    = done_q;
    assign bus.out_ate          = ate_q;
    assign bus.out_dead         = dead_q;
    assign bus.out_tick_overrun = ovr_q;

endmodule
